sw_word_assembler: RTL
======================

# sw_word_assembler

- Builds a 32-bit word from two 16-bit switch entries: high half on the first capture-button press, low half on the second.
- Presents the finished word to the downstream 32-bit datapath with a valid/ready handshake.
- Sits between the board switch/button inputs and the 32-bit mux feeding the display/LED split.
- It is the input-side counterpart of that split: it joins two 16-bit halves into one word, where the split takes one word apart.

## Interface
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required before a debounced button level changes (10 ms at 100 MHz). Used only with debounce compiled in. Minimum 2.
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous and active-low
- sw_in  input  16  board switches; asynchronous to clk
- capture_btn  input  1  capture push-button; asynchronous, active-high
- clear_btn  input  1  clear push-button; asynchronous, active-high
- word_ready  input  1  downstream accepts word_out
- word_out  output  32  assembled word {hi, lo}
- word_valid  output  1  word_out holds a complete word
- hi_loaded  output  1  high half captured, low half pending (status LED)
- xfer_count  output  8  completed handshakes, wraps 255 -> 0

## Operation
- sw_in, capture_btn and clear_btn each pass through a 2-flop synchronizer.
- Each button then goes through the optional debouncer, followed by a rising-edge detector.
- The edge detector yields one-cycle pulses cap_p and clr_p.
- Internal hi_reg and lo_reg are 16 bits each.
- word_out is {hi_reg, lo_reg} in every state.
- FSM states:
  - EMPTY (2'b00): cap_p -> hi_reg <= synced sw_in; go to HALF.
  - HALF (2'b01): cap_p -> lo_reg <= synced sw_in; go to FULL.
  - FULL (2'b10): word_valid = 1. On word_valid & word_ready, xfer_count += 1, then go to EMPTY. hi_reg and lo_reg are kept until overwritten.
- In FULL, cap_p is ignored and word_out stays stable until the handshake.
- clr_p from any state: go to EMPTY, hi_reg = lo_reg = 0.
- clr_p takes priority over cap_p in the same cycle.
- clr_p and a handshake in the same cycle:
  - The transfer counts and xfer_count increments.
  - State goes to EMPTY and the registers clear.
- Output decode is registered from state: hi_loaded = (state == HALF), word_valid = (state == FULL).
- Illegal state 2'b11 returns to EMPTY on the next edge.
- Reset values: state EMPTY, hi_reg = lo_reg = 0, word_out = 0, word_valid = 0, hi_loaded = 0, xfer_count = 0, all synchronizer, debounce and edge flops 0.
- Reset mid-operation discards any partial or pending word immediately, without waiting for a clock.

## Timing
- Button path without debounce:
  - The input is high at rising edge k.
  - The cap_p pulse is high in the cycle after edge k+1.
  - The register and state update land at edge k+2.
  - hi_loaded or word_valid is visible after edge k+2.
- Debounce adds DEBOUNCE_CYCLES cycles of latency on both press and release.
- sw_in is sampled from its synchronized copy at the capturing edge, i.e. the value present 2 edges earlier.
- Handshake follows valid/ready rules:
  - word_valid does not depend on word_ready.
  - word_ready may be held high permanently; the word then transfers on the first FULL cycle.
  - Minimum gap between two words is 2 button presses; there is no throughput limit in FULL.
- A held button produces exactly one pulse; a new pulse needs release and re-press.

## Configuration
- SW_WORD_ASSEMBLER_DEBOUNCE_EN defined:
  - Each synchronized button feeds a counter that resets whenever the raw level differs from the debounced level.
  - The debounced level flips once the counter reaches DEBOUNCE_CYCLES - 1.
- Undefined:
  - No counters; the synchronized level drives the edge detector directly.
  - DEBOUNCE_CYCLES is ignored.

## Test plan
- Reset, then press capture with sw_in = 16'hDEAD, then with 16'hBEEF, word_ready = 0 -> hi_loaded goes 1 then 0, word_valid = 1, word_out = 32'hDEADBEEF held stable for 20 cycles.
- From the previous state, raise word_ready for 1 cycle -> xfer_count = 1, word_valid = 0 the next cycle; a 3rd capture press while FULL earlier had no effect.
- Capture 16'h1234, then press clear -> hi_loaded = 0, next two captures 16'h0001 and 16'h0002 give word_out = 32'h00010002.
- Capture and clear rising in the same cycle while in HALF -> state EMPTY, registers 0, no low-half load.
- With the macro defined and DEBOUNCE_CYCLES = 4, capture glitches of 1-3 cycles -> no state change; a 6-cycle press -> exactly one capture.
- word_ready tied high and 256 words entered -> xfer_count wraps to 0; rst_n asserted while in HALF -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/sw_word_assembler.sv
// sw_word_assembler: joins two 16-bit switch captures into a 32-bit word and hands it off with a valid/ready handshake.
// Define SW_WORD_ASSEMBLER_DEBOUNCE_EN to add per-button debounce counters of DEBOUNCE_CYCLES.
module sw_word_assembler #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] sw_in,
  input  logic        capture_btn,
  input  logic        clear_btn,
  input  logic        word_ready,
  output logic [31:0] word_out,
  output logic        word_valid,
  output logic        hi_loaded,
  output logic [7:0]  xfer_count
);
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] HALF  = 2'b01;
  localparam logic [1:0] FULL  = 2'b10;
  logic [15:0] sw_s1_q, sw_s2_q, hi_q, hi_d, lo_q, lo_d;
  logic [1:0]  btn_s1_q, btn_s2_q, lvl, prev_q, state_q, state_d;
  logic [7:0]  xfer_q, xfer_d;
  logic        cap_p, clr_p;
  // bit 0 carries capture, bit 1 carries clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      prev_q   <= '0;
    end else begin
      sw_s1_q  <= sw_in;
      sw_s2_q  <= sw_s1_q;
      btn_s1_q <= {clear_btn, capture_btn};
      btn_s2_q <= btn_s1_q;
      prev_q   <= lvl;
    end
`ifdef SW_WORD_ASSEMBLER_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  for (genvar i = 0; i < 2; i++) begin : g_db
    logic [CW-1:0] cnt_q;
    logic          db_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        cnt_q <= '0;
        db_q  <= 1'b0;
      end else if (btn_s2_q[i] == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_q <= '0;
        db_q  <= btn_s2_q[i];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    assign lvl[i] = db_q;
  end
`else
  assign lvl = btn_s2_q;
`endif
  assign cap_p = lvl[0] & ~prev_q[0];
  assign clr_p = lvl[1] & ~prev_q[1];
  assign word_valid = (state_q == FULL);
  assign hi_loaded  = (state_q == HALF);
  assign word_out   = {hi_q, lo_q};
  assign xfer_count = xfer_q;
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    xfer_d  = (word_valid && word_ready) ? xfer_q + 8'd1 : xfer_q;
    if (clr_p) begin
      state_d = EMPTY;
      hi_d    = '0;
      lo_d    = '0;
    end else if (state_q == EMPTY) begin
      state_d = cap_p ? HALF : EMPTY;
      hi_d    = cap_p ? sw_s2_q : hi_q;
    end else if (state_q == HALF) begin
      state_d = cap_p ? FULL : HALF;
      lo_d    = cap_p ? sw_s2_q : lo_q;
    end else if (state_q == FULL) begin
      state_d = word_ready ? EMPTY : FULL;
    end else begin
      state_d = EMPTY;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= EMPTY;
      hi_q    <= '0;
      lo_q    <= '0;
      xfer_q  <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      xfer_q  <= xfer_d;
    end
endmodule
